// File: rtl/issue_fetch_pkg.sv
// Shared constants for the fetch front end: opcode values, FSM state
// encoding and the default predictor index width.
package issue_fetch_pkg;

    // Width of the predictor table index fields carried with each instruction.
    localparam int PRED_TABLE_BIT = 8;

    // RV32 major opcodes that affect the next fetch address.
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Fetch controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    // Sequential successor of a PC (32-bit wrap).
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/issue_fetch_imm_gen.sv
// Combinational immediate extraction for JAL (J-type) and conditional
// branches (B-type); both results are sign-extended to 32 bits.
module imm_gen (
    input  logic [31:0] inst_i,
    output logic [6:0]  opcode_o,
    output logic [31:0] j_imm_o,
    output logic [31:0] b_imm_o
);

    // Slice the instruction fields into opcode and the two immediates.
    always_comb begin
        opcode_o = inst_i[6:0];
        j_imm_o  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        b_imm_o  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    end

endmodule

// File: rtl/issue_fetch.sv
// Instruction fetch stage: requests one instruction at a time from the
// icache, queries the branch predictor with the returned word, computes the
// next PC and hands the instruction to the issue queue. Supports ROB
// redirects (flush) and a global stall (rdy_in low).
module issue_fetch
    import issue_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          PRED_BITS = PRED_TABLE_BIT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    output logic                 icache_req,
    output logic [31:0]          icache_addr,
    input  logic                 icache_valid,
    input  logic [31:0]          icache_inst,

    output logic                 pred_req,
    output logic [31:0]          pred_addr,
    input  logic [31:0]          pred_taken,
    input  logic [PRED_BITS-1:0] pred_g_ind,
    input  logic [PRED_BITS-1:0] pred_l_ind,

    input  logic                 iq_full,
    output logic                 iq_valid,
    output logic [31:0]          iq_inst,
    output logic [31:0]          iq_pc,
    output logic                 iq_pred,
    output logic [PRED_BITS-1:0] iq_g_ind,
    output logic [PRED_BITS-1:0] iq_l_ind,

    input  logic                 flush_in,
    input  logic [31:0]          flush_pc
);

    fetch_state_e         state_q;
    logic [31:0]          pc_q;
    logic                 icache_req_q;
    logic [31:0]          icache_addr_q;
    logic                 iq_valid_q;
    logic [31:0]          iq_inst_q;
    logic [31:0]          iq_pc_q;
    logic                 iq_pred_q;
    logic [PRED_BITS-1:0] iq_g_ind_q;
    logic [PRED_BITS-1:0] iq_l_ind_q;

    logic [6:0]           opcode_s;
    logic [31:0]          j_imm_s;
    logic [31:0]          b_imm_s;
    logic [31:0]          pc_d;
    logic                 pred_d;
    logic                 pred_taken_unused_s;

    // Only bit 0 of the prediction carries information.
    assign pred_taken_unused_s = ^pred_taken[31:1];

    imm_gen u_imm_gen (
        .inst_i   (icache_inst),
        .opcode_o (opcode_s),
        .j_imm_o  (j_imm_s),
        .b_imm_o  (b_imm_s)
    );

    // Next PC and predicted-taken flag for the instruction currently returned.
    always_comb begin
        pc_d   = pc_plus4(pc_q);
        pred_d = 1'b0;
        case (opcode_s)
            OPC_JAL: begin
                pc_d   = pc_q + j_imm_s;
                pred_d = 1'b1;
            end
            OPC_BRANCH: begin
                pred_d = pred_taken[0];
                if (pred_taken[0]) begin
                    pc_d = pc_q + b_imm_s;
                end else begin
                    pc_d = pc_plus4(pc_q);
                end
            end
            OPC_JALR: begin
                // Target is unknown here; fall through sequentially.
                pc_d   = pc_plus4(pc_q);
                pred_d = 1'b0;
            end
            default: begin
                pc_d   = pc_plus4(pc_q);
                pred_d = 1'b0;
            end
        endcase
    end

    // Fetch FSM with all datapath and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            icache_req_q  <= 1'b0;
            icache_addr_q <= 32'h0000_0000;
            iq_valid_q    <= 1'b0;
            iq_inst_q     <= 32'h0000_0000;
            iq_pc_q       <= 32'h0000_0000;
            iq_pred_q     <= 1'b0;
            iq_g_ind_q    <= '0;
            iq_l_ind_q    <= '0;
        end else if (rdy_in) begin
            // iq_valid is a single-cycle pulse unless set below.
            iq_valid_q <= 1'b0;
            if (flush_in) begin
                pc_q <= flush_pc;
                case (state_q)
                    ST_FETCH: begin
                        if (icache_valid) begin
                            // Response arrived with the flush: drop it now.
                            icache_req_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            // Request still outstanding: swallow its response later.
                            state_q <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (icache_valid) begin
                            icache_req_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q <= ST_DISCARD;
                        end
                    end
                    default: begin
                        // IDLE or HOLD: any held instruction is dropped.
                        state_q <= ST_IDLE;
                    end
                endcase
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!iq_full) begin
                            state_q       <= ST_FETCH;
                            icache_req_q  <= 1'b1;
                            icache_addr_q <= pc_q;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_FETCH: begin
                        if (icache_valid) begin
                            icache_req_q <= 1'b0;
                            iq_inst_q    <= icache_inst;
                            iq_pc_q      <= pc_q;
                            iq_pred_q    <= pred_d;
                            iq_g_ind_q   <= pred_g_ind;
                            iq_l_ind_q   <= pred_l_ind;
                            pc_q         <= pc_d;
                            if (!iq_full) begin
                                iq_valid_q <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                    ST_HOLD: begin
                        if (!iq_full) begin
                            iq_valid_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_DISCARD: begin
                        if (icache_valid) begin
                            icache_req_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q <= ST_DISCARD;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The predictor is queried in the same cycle the instruction word returns.
    always_comb begin
        pred_req  = (state_q == ST_FETCH) && icache_valid && rdy_in;
        pred_addr = pc_q;
    end

    assign icache_req  = icache_req_q;
    assign icache_addr = icache_addr_q;
    assign iq_valid    = iq_valid_q;
    assign iq_inst     = iq_inst_q;
    assign iq_pc       = iq_pc_q;
    assign iq_pred     = iq_pred_q;
    assign iq_g_ind    = iq_g_ind_q;
    assign iq_l_ind    = iq_l_ind_q;

endmodule

// File: tb/tb_issue_fetch.sv
// Directed bench for issue_fetch: a vector table of fetch transactions
// followed by hand-written HOLD, flush, stall and reset sequences.
module tb_issue_fetch;
    import issue_fetch_pkg::*;

    localparam int PB = PRED_TABLE_BIT;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          icache_req;
    logic [31:0]   icache_addr;
    logic          icache_valid;
    logic [31:0]   icache_inst;
    logic          pred_req;
    logic [31:0]   pred_addr;
    logic [31:0]   pred_taken;
    logic [PB-1:0] pred_g_ind;
    logic [PB-1:0] pred_l_ind;
    logic          iq_full;
    logic          iq_valid;
    logic [31:0]   iq_inst;
    logic [31:0]   iq_pc;
    logic          iq_pred;
    logic [PB-1:0] iq_g_ind;
    logic [PB-1:0] iq_l_ind;
    logic          flush_in;
    logic [31:0]   flush_pc;

    issue_fetch dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_valid (icache_valid),
        .icache_inst  (icache_inst),
        .pred_req     (pred_req),
        .pred_addr    (pred_addr),
        .pred_taken   (pred_taken),
        .pred_g_ind   (pred_g_ind),
        .pred_l_ind   (pred_l_ind),
        .iq_full      (iq_full),
        .iq_valid     (iq_valid),
        .iq_inst      (iq_inst),
        .iq_pc        (iq_pc),
        .iq_pred      (iq_pred),
        .iq_g_ind     (iq_g_ind),
        .iq_l_ind     (iq_l_ind),
        .flush_in     (flush_in),
        .flush_pc     (flush_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic [31:0]   taken;
        logic [PB-1:0] g;
        logic [PB-1:0] l;
        logic          pred;
        logic [31:0]   next;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[11];

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] taken, input logic [7:0] g,
                                input logic [7:0] l, input logic pred,
                                input logic [31:0] nx);
        vec_t v;
        v.pc    = pc;
        v.inst  = inst;
        v.taken = taken;
        v.g     = PB'(g);
        v.l     = PB'(l);
        v.pred  = pred;
        v.next  = nx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge; waits (bounded) for a request and checks its address.
    task automatic wait_req(input logic [31:0] exp, input string nm);
        int n;
        n = 0;
        while (icache_req !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        chk({nm, "_req"}, 32'(icache_req), 32'd1);
        chk(nm, icache_addr, exp);
    endtask

    // Serve one fetch with the vector's instruction and check delivery and next address.
    task automatic apply_vec(input vec_t v);
        wait_req(v.pc, "addr");
        icache_valid = 1'b1;
        icache_inst  = v.inst;
        pred_taken   = v.taken;
        pred_g_ind   = v.g;
        pred_l_ind   = v.l;
        #1;
        chk("pred_req", 32'(pred_req), 32'd1);
        chk("pred_addr", pred_addr, v.pc);
        @(negedge clk_in);
        icache_valid = 1'b0;
        icache_inst  = 32'h0;
        pred_taken   = 32'h0;
        chk("iq_valid", 32'(iq_valid), 32'd1);
        chk("iq_inst", iq_inst, v.inst);
        chk("iq_pc", iq_pc, v.pc);
        chk("iq_pred", 32'(iq_pred), 32'(v.pred));
        chk("iq_g_ind", 32'(iq_g_ind), 32'(v.g));
        chk("iq_l_ind", 32'(iq_l_ind), 32'(v.l));
        chk("req_drop", 32'(icache_req), 32'd0);
        @(negedge clk_in);
        chk("iq_valid_pulse", 32'(iq_valid), 32'd0);
        wait_req(v.next, "next_addr");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(32'd0,  32'h0000_0013, 32'h0,         8'h01, 8'h02, 1'b0, 32'd4);
        vecs[1]  = mk(32'd4,  32'h0000_0013, 32'h0,         8'h03, 8'h04, 1'b0, 32'd8);
        vecs[2]  = mk(32'd8,  32'h0100_006F, 32'h0,         8'h05, 8'h06, 1'b1, 32'd24);
        vecs[3]  = mk(32'd24, 32'h0000_8067, 32'h1,         8'h07, 8'h08, 1'b0, 32'd28);
        vecs[4]  = mk(32'd28, 32'h0000_0013, 32'h0,         8'h09, 8'h0A, 1'b0, 32'd32);
        vecs[5]  = mk(32'd32, 32'hFE00_0CE3, 32'hFFFF_FFFF, 8'hA5, 8'h3C, 1'b1, 32'd24);
        vecs[6]  = mk(32'd24, 32'h0000_0013, 32'h0,         8'h11, 8'h22, 1'b0, 32'd28);
        vecs[7]  = mk(32'd28, 32'h0000_0013, 32'h0,         8'h33, 8'h44, 1'b0, 32'd32);
        vecs[8]  = mk(32'd32, 32'hFE00_0CE3, 32'hFFFF_FFFE, 8'h5A, 8'hC3, 1'b0, 32'd36);
        vecs[9]  = mk(32'd36, 32'hFFDF_F06F, 32'h0,         8'h66, 8'h77, 1'b1, 32'd32);
        vecs[10] = mk(32'd32, 32'h0000_0013, 32'h1,         8'h88, 8'h99, 1'b0, 32'd36);

        rst_in       = 1'b1;
        rdy_in       = 1'b0;
        icache_valid = 1'b0;
        icache_inst  = 32'h0;
        pred_taken   = 32'h0;
        pred_g_ind   = '0;
        pred_l_ind   = '0;
        iq_full      = 1'b0;
        flush_in     = 1'b0;
        flush_pc     = 32'h0;

        // Reset state, held across rdy_in low and high.
        @(negedge clk_in);
        rdy_in = 1'b1;
        @(negedge clk_in);
        chk("rst_req", 32'(icache_req), 32'd0);
        chk("rst_iq_valid", 32'(iq_valid), 32'd0);
        chk("rst_pred_req", 32'(pred_req), 32'd0);
        chk("rst_pc", pred_addr, 32'd0);
        chk("rst_iq_inst", iq_inst, 32'd0);
        chk("rst_iq_pc", iq_pc, 32'd0);
        chk("rst_iq_pred", 32'(iq_pred), 32'd0);
        chk("rst_g_ind", 32'(iq_g_ind), 32'd0);
        rst_in = 1'b0;

        // Table of sequential fetch transactions.
        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i]);
        end

        // Queue full for three cycles when the response arrives.
        icache_valid = 1'b1;
        icache_inst  = 32'h0010_0093;
        iq_full      = 1'b1;
        @(negedge clk_in);
        icache_valid = 1'b0;
        chk("hold_v0", 32'(iq_valid), 32'd0);
        chk("hold_pc", iq_pc, 32'd36);
        chk("hold_req", 32'(icache_req), 32'd0);
        @(negedge clk_in);
        chk("hold_v1", 32'(iq_valid), 32'd0);
        @(negedge clk_in);
        chk("hold_v2", 32'(iq_valid), 32'd0);
        iq_full = 1'b0;
        @(negedge clk_in);
        chk("hold_release", 32'(iq_valid), 32'd1);
        chk("hold_inst", iq_inst, 32'h0010_0093);
        @(negedge clk_in);
        chk("hold_no_dup", 32'(iq_valid), 32'd0);
        wait_req(32'd40, "hold_next");

        // Flush during FETCH, then again during DISCARD.
        flush_in = 1'b1;
        flush_pc = 32'h0000_0080;
        @(negedge clk_in);
        chk("disc_req", 32'(icache_req), 32'd1);
        chk("disc_addr", icache_addr, 32'd40);
        flush_pc = 32'h0000_0100;
        @(negedge clk_in);
        flush_in = 1'b0;
        chk("disc_addr2", icache_addr, 32'd40);
        icache_valid = 1'b1;
        icache_inst  = 32'h0000_0013;
        #1;
        chk("disc_pred_req", 32'(pred_req), 32'd0);
        @(negedge clk_in);
        icache_valid = 1'b0;
        chk("disc_iq_valid", 32'(iq_valid), 32'd0);
        chk("disc_req_drop", 32'(icache_req), 32'd0);
        wait_req(32'h0000_0100, "flush_target");
        apply_vec(mk(32'h100, 32'h0000_0013, 32'h0, 8'h12, 8'h34, 1'b0, 32'h104));

        // Flush coincident with the response: dropped, no DISCARD.
        icache_valid = 1'b1;
        icache_inst  = 32'h0000_0013;
        flush_in     = 1'b1;
        flush_pc     = 32'hFFFF_FFFC;
        @(negedge clk_in);
        icache_valid = 1'b0;
        flush_in     = 1'b0;
        chk("coinc_iq_valid", 32'(iq_valid), 32'd0);
        chk("coinc_req", 32'(icache_req), 32'd0);
        @(negedge clk_in);
        chk("coinc_iq_valid2", 32'(iq_valid), 32'd0);
        wait_req(32'hFFFF_FFFC, "coinc_target");
        apply_vec(mk(32'hFFFF_FFFC, 32'h0000_0013, 32'h0, 8'h0F, 8'hF0, 1'b0, 32'h0));

        // Stall for two cycles with an ignored response pulse.
        rdy_in       = 1'b0;
        icache_valid = 1'b1;
        icache_inst  = 32'h0100_006F;
        #1;
        chk("stall_pred_req", 32'(pred_req), 32'd0);
        @(negedge clk_in);
        icache_valid = 1'b0;
        chk("stall_req1", 32'(icache_req), 32'd1);
        chk("stall_addr1", icache_addr, 32'd0);
        chk("stall_iq_valid", 32'(iq_valid), 32'd0);
        chk("stall_iq_pc", iq_pc, 32'hFFFF_FFFC);
        @(negedge clk_in);
        chk("stall_req2", 32'(icache_req), 32'd1);
        chk("stall_addr2", icache_addr, 32'd0);
        rdy_in = 1'b1;
        apply_vec(mk(32'd0, 32'h0000_0013, 32'h0, 8'h21, 8'h43, 1'b0, 32'd4));

        // Asynchronous reset in the middle of a fetch.
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_req", 32'(icache_req), 32'd0);
        chk("arst_iq_pc", iq_pc, 32'd0);
        chk("arst_pc", pred_addr, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        wait_req(32'd0, "post_rst");
        apply_vec(mk(32'd0, 32'h0000_0013, 32'h0, 8'h55, 8'hAA, 1'b0, 32'd4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_fetch.md
ISSUE_FETCH -- requirements
Module: issue_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter PRED_BITS, default `PRED_TABLE_BIT (const.v), width of predictor index fields.
REQ-003 clk_in  input  1  sole clock, all state on rising edge.
REQ-004 rst_in  input  1  asynchronous active-high reset.
REQ-005 rdy_in  input  1  low = freeze all state, outputs hold.
REQ-006 icache_req  output  1  fetch request, held high until icache_valid.
REQ-007 icache_addr  output  32  word-aligned fetch address, stable while icache_req high.
REQ-008 icache_valid  input  1  one-cycle pulse, icache_inst valid.
REQ-009 icache_inst  input  32  fetched instruction.
REQ-010 pred_req  output  1  predictor query strobe, equals icache_valid during FETCH.
REQ-011 pred_addr  output  32  equals current PC.
REQ-012 pred_taken  input  32  combinational prediction, bit 0 only used.
REQ-013 pred_g_ind, pred_l_ind  input  PRED_BITS each  predictor indices to forward.
REQ-014 iq_full  input  1  downstream queue cannot accept this cycle.
REQ-015 iq_valid  output  1  registered, one pulse per delivered instruction.
REQ-016 iq_inst, iq_pc  output  32 each  instruction and its PC.
REQ-017 iq_pred  output  1  predicted taken (branch) or 1 (JAL).
REQ-018 iq_g_ind, iq_l_ind  output  PRED_BITS each  forwarded predictor indices.
REQ-019 flush_in  input  1  ROB mispredict redirect.
REQ-020 flush_pc  input  32  redirect target.

Function
REQ-021 States: IDLE, FETCH, HOLD, DISCARD; 2-bit encoding.
REQ-022 IDLE: if !iq_full -> FETCH, icache_req=1, icache_addr=PC; else stay.
REQ-023 FETCH: on icache_valid, latch inst/PC/pred/indices into output regs, iq_valid=1 next cycle if !iq_full (-> IDLE with next PC), else -> HOLD.
REQ-024 HOLD: outputs held, iq_valid=0; first cycle iq_full=0 -> iq_valid=1 for one cycle, -> IDLE.
REQ-025 Next PC: opcode 1101111 (JAL) -> PC+J-imm; 1100011 (branch) -> pred_taken[0] ? PC+B-imm : PC+4; all others incl. JALR -> PC+4; 32-bit wrap, sign-extended immediates.
REQ-026 Throughput: at most one instruction per two cycles; latency icache_valid -> iq_valid = 1 cycle when not full.
REQ-027 flush_in (rdy_in high) overrides all: PC<=flush_pc, iq_valid=0, held instruction dropped; from FETCH -> DISCARD, otherwise -> IDLE.
REQ-028 DISCARD: icache_req stays high with old address until icache_valid, response dropped, pred_req=0, -> IDLE; flush in DISCARD updates PC only.
REQ-029 flush coincident with icache_valid in FETCH: response dropped, -> IDLE (no DISCARD).
REQ-030 rdy_in low: no state, PC or output change; icache_valid/flush_in ignored that cycle.

Reset
REQ-031 rst_in asynchronously forces state IDLE, PC=RESET_PC, icache_req=0, pred_req=0, iq_valid=0, iq_inst/iq_pc=0, iq_pred=0, indices=0; held for any rdy_in.
REQ-032 Reset mid-FETCH abandons request; no DISCARD after reset.

Structure
REQ-033 Opcode constants (JAL, JALR, BRANCH) and state encoding in const.v.
REQ-034 One sub-module imm_gen: combinational J/B immediate extraction, sign-extended to 32 bits.

Verification
REQ-035 Reset, PC=0, inst 32'h0000_0013 (addi) -> iq_valid with iq_pc=0, next icache_addr=4.
REQ-036 JAL +16 at PC=8 -> iq_pred=1, next icache_addr=24.
REQ-037 Branch imm -8 at PC=32: pred_taken=1 -> next 24; pred_taken=0 -> next 36; g/l indices forwarded unchanged.
REQ-038 iq_full high 3 cycles at response -> HOLD, iq_valid once after release, no duplicate.
REQ-039 flush_in, flush_pc=0x100 during FETCH -> pending response dropped, next icache_addr=0x100, no iq_valid for old PC.
REQ-040 rdy_in low 2 cycles with icache_valid pulse ignored -> all outputs frozen, fetch resumes unchanged.
